// File: rtl/block_feeder_pkg.sv
// Shared constants and read-side state encoding for the block feeder.
package block_feeder_pkg;

  localparam int ROWS       = 8;
  localparam int PIX_W      = 8;
  localparam int ROW_W      = 8 * PIX_W;
  localparam int GAP_CYCLES = 1;
  localparam int ROW_IDX_W  = $clog2(ROWS);
  localparam int GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_BURST = 2'd1,
    RD_GAP   = 2'd2
  } rd_state_t;

endpackage

// File: rtl/block_feeder_row_bank.sv
// One block-pair buffer: ROWS entries of {filter row, reference row}.
// Synchronous write, registered read; the read register is the burst output stage.
module row_bank
  import block_feeder_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [ROW_IDX_W-1:0] waddr,
  input  logic [2*ROW_W-1:0]   wdata,
  input  logic                 re,
  input  logic [ROW_IDX_W-1:0] raddr,
  output logic [2*ROW_W-1:0]   rdata
);

  logic [2*ROW_W-1:0] mem [ROWS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/block_feeder.sv
// Buffers 8x8 filter/reference block pairs and replays each as an unstalled burst.
// Define BLOCK_FEEDER_PINGPONG_EN for two banks (load overlaps burst); default is one bank.
//
// state    | meaning
// RD_IDLE  | outputs idle, waiting for the read bank to fill
// RD_BURST | one buffered row per cycle on filter_pix/ref_pix, input_ready high
// RD_GAP   | input_ready low for GAP_CYCLES, block_done pulses in the first
module block_feeder
  import block_feeder_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sob,
  input  logic [ROW_W-1:0] in_filt_row,
  input  logic [ROW_W-1:0] in_ref_row,
  output logic [ROW_W-1:0] filter_pix,
  output logic [ROW_W-1:0] ref_pix,
  output logic             input_ready,
  output logic             block_done,
  output logic             sync_err
);

`ifdef BLOCK_FEEDER_PINGPONG_EN
  localparam logic PINGPONG = 1'b1;
`else
  localparam logic PINGPONG = 1'b0;
`endif

  logic [1:0]           full;
  logic                 wr_bank, rd_bank, out_sel;
  logic [ROW_IDX_W-1:0] wr_row, wr_addr, rd_row, rd_row_n;
  logic [GAP_W-1:0]     gap_cnt, gap_cnt_n;
  rd_state_t            rd_state, rd_state_n;
  logic                 accept, wr_en, wr_last;
  logic                 rd_en, rd_start, rd_free, block_done_n;
  logic [2*ROW_W-1:0]   bank_rdata [2];
  logic [2*ROW_W-1:0]   rd_word;

  assign in_ready = !full[wr_bank];
  assign accept   = in_valid && in_ready;
  assign wr_en    = accept && (in_sob || wr_row != '0);
  assign wr_addr  = in_sob ? '0 : wr_row;
  assign wr_last  = wr_en && !in_sob && (wr_row == ROW_IDX_W'(ROWS - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_row   <= '0;
      wr_bank  <= 1'b0;
      sync_err <= 1'b0;
    end else if (accept) begin
      if (in_sob) begin
        wr_row <= ROW_IDX_W'(1);
        if (wr_row != '0) sync_err <= 1'b1;
      end else if (wr_row == '0) begin
        sync_err <= 1'b1;
      end else if (wr_last) begin
        wr_row  <= '0;
        wr_bank <= wr_bank ^ PINGPONG;
      end else begin
        wr_row <= wr_row + 1'b1;
      end
    end
  end

  // A bank is never written while full, so set and clear never target the same bank.
  always_ff @(posedge clk) begin
    if (!reset) begin
      full <= '0;
    end else begin
      if (wr_last) full[wr_bank] <= 1'b1;
      if (rd_free) full[rd_bank] <= 1'b0;
    end
  end

  // Ping-pong frees the bank as its last row is read so the writer never stalls;
  // a single bank is freed once the burst has completely left the output stage.
  always_comb begin
    rd_state_n   = rd_state;
    rd_row_n     = rd_row;
    gap_cnt_n    = gap_cnt;
    rd_en        = 1'b0;
    rd_start     = 1'b0;
    rd_free      = 1'b0;
    block_done_n = 1'b0;
    unique case (rd_state)
      RD_IDLE: begin
        if (full[rd_bank]) rd_start = 1'b1;
      end
      RD_BURST: begin
        if (rd_row == '0) begin
          rd_state_n   = RD_GAP;
          gap_cnt_n    = GAP_W'(GAP_CYCLES - 1);
          block_done_n = 1'b1;
          rd_free      = !PINGPONG;
        end else begin
          rd_en    = 1'b1;
          rd_row_n = rd_row + 1'b1;
          rd_free  = PINGPONG && (rd_row == ROW_IDX_W'(ROWS - 1));
        end
      end
      RD_GAP: begin
        if (gap_cnt != '0)       gap_cnt_n  = gap_cnt - 1'b1;
        else if (full[rd_bank])  rd_start   = 1'b1;
        else                     rd_state_n = RD_IDLE;
      end
      default: rd_state_n = RD_IDLE;
    endcase
    if (rd_start) begin
      rd_state_n = RD_BURST;
      rd_en      = 1'b1;
      rd_row_n   = rd_row + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_state   <= RD_IDLE;
      rd_row     <= '0;
      gap_cnt    <= '0;
      rd_bank    <= 1'b0;
      out_sel    <= 1'b0;
      block_done <= 1'b0;
    end else begin
      rd_state   <= rd_state_n;
      rd_row     <= rd_row_n;
      gap_cnt    <= gap_cnt_n;
      block_done <= block_done_n;
      if (rd_start) out_sel <= rd_bank;
      if (rd_free)  rd_bank <= rd_bank ^ PINGPONG;
    end
  end

  assign input_ready = (rd_state == RD_BURST);

  row_bank u_bank0 (
    .clk   (clk),
    .reset (reset),
    .we    (wr_en && !wr_bank),
    .waddr (wr_addr),
    .wdata ({in_filt_row, in_ref_row}),
    .re    (rd_en && !rd_bank),
    .raddr (rd_row),
    .rdata (bank_rdata[0])
  );

  generate
    if (PINGPONG) begin : g_pingpong
      row_bank u_bank1 (
        .clk   (clk),
        .reset (reset),
        .we    (wr_en && wr_bank),
        .waddr (wr_addr),
        .wdata ({in_filt_row, in_ref_row}),
        .re    (rd_en && rd_bank),
        .raddr (rd_row),
        .rdata (bank_rdata[1])
      );
    end else begin : g_single
      assign bank_rdata[1] = '0;
    end
  endgenerate

  assign rd_word    = bank_rdata[out_sel];
  assign filter_pix = rd_word[2*ROW_W-1:ROW_W];
  assign ref_pix    = rd_word[ROW_W-1:0];

endmodule

// File: tb/tb_block_feeder.sv
// Directed bench for block_feeder: sync checks, burst timing, reset abort, random-valid scoreboard.
module tb_block_feeder;
  import block_feeder_pkg::*;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_sob = 1'b0;
  logic [ROW_W-1:0] in_filt_row = '0;
  logic [ROW_W-1:0] in_ref_row = '0;
  logic [ROW_W-1:0] filter_pix, ref_pix;
  logic             input_ready, block_done, sync_err;

  block_feeder dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sob      (in_sob),
    .in_filt_row (in_filt_row),
    .in_ref_row  (in_ref_row),
    .filter_pix  (filter_pix),
    .ref_pix     (ref_pix),
    .input_ready (input_ready),
    .block_done  (block_done),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errs = 0;
  int cyc = 0;
  int acc_cyc, last_wait, first_wait, total_wait, run_len;
  logic prev_ir = 1'b0;
  logic [2*ROW_W-1:0] exp_q[$];
  logic [2*ROW_W-1:0] got_q[$];
  int starts_q[$];
  int done_q[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ROW_W-1:0] rf(input int b, input int r);
    logic [7:0] p;
    p = 8'(b * 16 + r);
    return {8{p}};
  endfunction

  task automatic tick();
    logic rst_edge;
    rst_edge = reset;
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_edge) begin
      run_len = 0;
      prev_ir = 1'b0;
      return;
    end
    if (input_ready) begin
      if (!prev_ir) starts_q.push_back(cyc);
      run_len++;
      got_q.push_back({filter_pix, ref_pix});
    end else if (prev_ir) begin
      chk("burst_len", run_len, ROWS);
      run_len = 0;
    end
    if (block_done) begin
      chk("done_after_burst", prev_ir && !input_ready, 1);
      done_q.push_back(cyc);
    end
    prev_ir = input_ready;
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    in_valid = 1'b0;
    in_sob = 1'b0;
    in_filt_row = '0;
    in_ref_row = '0;
    tick();
    tick();
    reset = 1'b1;
    exp_q.delete();
    got_q.delete();
    starts_q.delete();
    done_q.delete();
    total_wait = 0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_sob = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_row(input logic sob, input logic [ROW_W-1:0] f, input logic [ROW_W-1:0] r);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_sob = sob;
    in_filt_row = f;
    in_ref_row = r;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) chk("send_timeout", in_ready, 1);
    last_wait = n;
    total_wait += n;
    tick();
    acc_cyc = cyc;
    in_sob = 1'b0;
  endtask

  task automatic send_block(input int b, input bit push);
    for (int r = 0; r < ROWS; r++) begin
      send_row(r == 0, rf(b, r), ~rf(b, r));
      if (r == 0) first_wait = last_wait;
      if (push) exp_q.push_back({rf(b, r), ~rf(b, r)});
    end
  endtask

  task automatic check_sb(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) chk(tag, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int e, w2, w3;
    bit done;
    int guard;
    logic [ROW_W-1:0] f, r;

    // 1: reset state, then a single block
    reset_dut();
    chk("rst_filter_pix", filter_pix, 0);
    chk("rst_ref_pix", ref_pix, 0);
    chk("rst_input_ready", input_ready, 0);
    chk("rst_block_done", block_done, 0);
    chk("rst_sync_err", sync_err, 0);
    chk("rst_in_ready", in_ready, 1);
    send_block(0, 1);
    e = acc_cyc;
    idle(14);
    chk("t1_bursts", starts_q.size(), 1);
    if (starts_q.size() == 1) chk("t1_latency", starts_q[0] - e, 1);
    chk("t1_dones", done_q.size(), 1);
    if (done_q.size() == 1) chk("t1_done_cycle", done_q[0] - e, 9);
    chk("t1_in_ready", in_ready, 1);
    chk("t1_sync_err", sync_err, 0);
    check_sb("t1_data");

    // 2: three blocks back to back, valid held high
    reset_dut();
    send_block(1, 1);
    send_block(2, 1);
    w2 = first_wait;
    send_block(3, 1);
    w3 = first_wait;
    idle(50);
    chk("t2_bursts", starts_q.size(), 3);
`ifdef BLOCK_FEEDER_PINGPONG_EN
    chk("t2_total_wait", total_wait, 0);
    if (starts_q.size() == 3) begin
      chk("t2_spacing_ab", starts_q[1] - starts_q[0], 9);
      chk("t2_spacing_bc", starts_q[2] - starts_q[1], 9);
    end
`else
    chk("t2_wait_b", w2, 9);
    chk("t2_wait_c", w3, 9);
    chk("t2_total_wait", total_wait, 18);
    if (starts_q.size() == 3) begin
      chk("t2_spacing_ab", starts_q[1] - starts_q[0], 17);
      chk("t2_spacing_bc", starts_q[2] - starts_q[1], 17);
    end
`endif
    check_sb("t2_data");

    // 3: sob at row 5 restarts the block
    reset_dut();
    for (int i = 0; i < 5; i++) send_row(i == 0, rf(3, i), ~rf(3, i));
    chk("t3_sync_before", sync_err, 0);
    send_block(4, 1);
    idle(14);
    chk("t3_sync_err", sync_err, 1);
    chk("t3_bursts", starts_q.size(), 1);
    check_sb("t3_data");

    // 4: row 0 without sob is dropped
    reset_dut();
    send_row(1'b0, rf(5, 0), ~rf(5, 0));
    idle(1);
    chk("t4_sync_err", sync_err, 1);
    idle(12);
    chk("t4_no_burst", starts_q.size(), 0);
    send_block(6, 1);
    idle(14);
    chk("t4_bursts", starts_q.size(), 1);
    chk("t4_sync_sticky", sync_err, 1);
    check_sb("t4_data");

    // 5: reset during burst row 3
    reset_dut();
    send_block(7, 0);
    in_valid = 1'b0;
    repeat (4) tick();
    chk("t5_row3_valid", input_ready, 1);
    chk("t5_row3_data", filter_pix, rf(7, 3));
    reset = 1'b0;
    tick();
    chk("t5_filter_zero", filter_pix, 0);
    chk("t5_ref_zero", ref_pix, 0);
    chk("t5_ir_zero", input_ready, 0);
    chk("t5_done_zero", block_done, 0);
    reset = 1'b1;
    chk("t5_in_ready", in_ready, 1);
    idle(20);
    chk("t5_no_resume", input_ready, 0);
    chk("t5_bursts", starts_q.size(), 1);
    for (int i = 0; i < 4; i++) exp_q.push_back({rf(7, i), ~rf(7, i)});
    check_sb("t5_data");

    // 6: random in_valid over 20 blocks
    reset_dut();
    for (int b = 0; b < 20; b++) begin
      for (int i = 0; i < ROWS; i++) begin
        f = {$urandom, $urandom};
        r = {$urandom, $urandom};
        done = 1'b0;
        guard = 0;
        while (!done && guard < 400) begin
          in_valid = 1'($urandom_range(0, 1));
          in_sob = (i == 0);
          in_filt_row = f;
          in_ref_row = r;
          done = in_valid && in_ready;
          tick();
          guard++;
        end
        if (!done) chk("t6_timeout", done, 1);
        exp_q.push_back({f, r});
      end
    end
    idle(60);
    chk("t6_dones", done_q.size(), 20);
    chk("t6_sync_err", sync_err, 0);
    check_sb("t6_data");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
